// File: rtl/sar_conv_ctrl.sv
// Sequencer for one SAR ADC conversion: sample, then a comparator reset/evaluate pair per bit,
// MSB first, with a per-bit evaluate timeout. All outputs are registered.
module sar_conv_ctrl #(
    parameter int unsigned NBITS         = 8,
    parameter int unsigned SAMPLE_CYCLES = 4,
    parameter int unsigned RESET_CYCLES  = 1,
    parameter int unsigned TIMEOUT       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             comp_p,
    input  logic             comp_n,
    output logic             busy,
    output logic             sample,
    output logic             comp_clk,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] result,
    output logic             result_valid,
    output logic             timeout_flag
);

    localparam int unsigned CntMax01 = (SAMPLE_CYCLES > RESET_CYCLES) ? SAMPLE_CYCLES
                                                                      : RESET_CYCLES;
    localparam int unsigned CntMax   = (CntMax01 > TIMEOUT) ? CntMax01 : TIMEOUT;
    localparam int unsigned CW       = $clog2(CntMax + 1);
    localparam int unsigned IW       = $clog2(NBITS);

    typedef enum logic [2:0] {StIdle, StSample, StCompRst, StCompEval, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     bit_q, bit_d;
    logic [NBITS-1:0]  dac_q, dac_d;
    logic              to_acc_q, to_acc_d;
    logic [NBITS-1:0]  result_q, result_d;
    logic              sample_q, sample_d;
    logic              comp_clk_q, comp_clk_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              tflag_q, tflag_d;
    logic              decision;

    // Both-high (regenerating) and both-low (reset) mean no decision yet.
    assign decision = comp_p ^ comp_n;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        dac_d    = dac_q;
        to_acc_d = to_acc_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSample;
                    cnt_d   = '0;
                end
            end
            StSample: begin
                if (cnt_q == CW'(SAMPLE_CYCLES - 1)) begin
                    state_d  = StCompRst;
                    cnt_d    = '0;
                    dac_d    = {1'b1, {(NBITS-1){1'b0}}};
                    bit_d    = IW'(NBITS - 1);
                    to_acc_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCompRst: begin
                if (cnt_q == CW'(RESET_CYCLES - 1)) begin
                    state_d = StCompEval;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCompEval: begin
                if (decision || (cnt_q == CW'(TIMEOUT - 1))) begin
                    // A timed-out bit resolves to 0 and is remembered for the flag.
                    dac_d[bit_q] = decision ? comp_p : 1'b0;
                    if (!decision) begin
                        to_acc_d = 1'b1;
                    end
                    cnt_d = '0;
                    if (bit_q != '0) begin
                        dac_d[bit_q - 1'b1] = 1'b1;
                        bit_d               = bit_q - 1'b1;
                        state_d             = StCompRst;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they leave flops cleanly.
        sample_d   = (state_d == StSample);
        comp_clk_d = (state_d == StCompEval);
        busy_d     = (state_d != StIdle);
        valid_d    = (state_d == StDone);
        result_d   = (state_d == StDone) ? dac_d : result_q;
        tflag_d    = (state_d == StDone) ? to_acc_d : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            dac_q      <= '0;
            to_acc_q   <= 1'b0;
            result_q   <= '0;
            sample_q   <= 1'b0;
            comp_clk_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            tflag_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            dac_q      <= dac_d;
            to_acc_q   <= to_acc_d;
            result_q   <= result_d;
            sample_q   <= sample_d;
            comp_clk_q <= comp_clk_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            tflag_q    <= tflag_d;
        end
    end

    assign busy         = busy_q;
    assign sample       = sample_q;
    assign comp_clk     = comp_clk_q;
    assign dac_code     = dac_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign timeout_flag = tflag_q;

endmodule
